// File: rtl/array_multiplier_pipe.sv
// array_multiplier_pipe
//   Pipelined WIDTH x WIDTH array multiplier. The partial-product rows are
//   spread over STAGES register stages, with WIDTH/STAGES rows per stage, and
//   the block can accept one operand pair per cycle. Downstream backpressure
//   stalls the whole pipeline in place.
//   Optional feature macro: ARRAY_MULT_SIGNED_EN. When it is defined, the
//   in_signed port is added and Baugh-Wooley two's-complement products are
//   supported. When it is undefined, the block is unsigned only.
module array_multiplier_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
`ifdef ARRAY_MULT_SIGNED_EN
  input  logic                 in_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result
);

  localparam int ROWS = WIDTH / STAGES;
  localparam int PW   = 2 * WIDTH;
  localparam int IW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef ARRAY_MULT_SIGNED_EN
  // Baugh-Wooley constant: 2^WIDTH + 2^(2*WIDTH-1), taken modulo 2^(2*WIDTH)
  localparam logic [PW-1:0] BW_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] BW_CONST = (BW_ONE << WIDTH) | (BW_ONE << (PW - 1));

  // Sum of the rows owned by stage k. The signed form inverts the sign
  // column in rows 0..WIDTH-2 and the magnitude bits of the MSB row.
  // The constant term is added in the stage that owns the MSB row.
  function automatic logic [PW-1:0] stage_rows(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input int k,
                                               input logic sgn);
    logic [PW-1:0] acc;
    logic [PW-1:0] row;
    logic [IW-1:0] idx;
    acc = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = IW'(k * ROWS + r);
      row = '0;
      row[WIDTH-1:0] = a & {WIDTH{b[idx]}};
      if (sgn) begin
        if (idx == IW'(WIDTH - 1)) row[WIDTH-2:0] = ~row[WIDTH-2:0];
        else                       row[WIDTH-1]   = ~row[WIDTH-1];
      end
      acc = acc + (row << idx);
    end
    if (sgn && (k == STAGES - 1)) acc = acc + BW_CONST;
    return acc;
  endfunction
`else
  // Sum of the rows owned by stage k: row i is (a & {WIDTH{b[i]}}) << i.
  function automatic logic [PW-1:0] stage_rows(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input int k);
    logic [PW-1:0] acc;
    logic [PW-1:0] row;
    logic [IW-1:0] idx;
    acc = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = IW'(k * ROWS + r);
      row = '0;
      row[WIDTH-1:0] = a & {WIDTH{b[idx]}};
      acc = acc + (row << idx);
    end
    return acc;
  endfunction
`endif

  logic              valid_reg [STAGES];
  logic [WIDTH-1:0]  a_reg     [STAGES];
  logic [WIDTH-1:0]  b_reg     [STAGES];
  logic [PW-1:0]     sum_reg   [STAGES];
`ifdef ARRAY_MULT_SIGNED_EN
  logic              sgn_reg   [STAGES];
`endif
  logic              stall;

  // The pipeline advances as a unit. It freezes only when the final result is
  // waiting and the consumer has not taken it.
  assign stall      = valid_reg[STAGES-1] && !out_ready;
  assign in_ready   = !stall;
  assign out_valid  = valid_reg[STAGES-1];
  assign out_result = sum_reg[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             valid_src;
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [PW-1:0]    sum_src;
      logic [PW-1:0]    sum_next;
`ifdef ARRAY_MULT_SIGNED_EN
      logic             sgn_src;
`endif

      if (gi == 0) begin : g_src_in
        // Stage 0 starts from an empty sum. While advancing, in_ready is high,
        // so in_valid alone marks an accepted pair.
        assign valid_src = in_valid;
        assign a_src     = in_a;
        assign b_src     = in_b;
        assign sum_src   = '0;
`ifdef ARRAY_MULT_SIGNED_EN
        assign sgn_src   = in_signed;
`endif
      end else begin : g_src_prev
        assign valid_src = valid_reg[gi-1];
        assign a_src     = a_reg[gi-1];
        assign b_src     = b_reg[gi-1];
        assign sum_src   = sum_reg[gi-1];
`ifdef ARRAY_MULT_SIGNED_EN
        assign sgn_src   = sgn_reg[gi-1];
`endif
      end

`ifdef ARRAY_MULT_SIGNED_EN
      assign sum_next = sum_src + stage_rows(a_src, b_src, gi, sgn_src);
`else
      assign sum_next = sum_src + stage_rows(a_src, b_src, gi);
`endif

      // Stage register: clears on reset, holds on stall, and otherwise loads
      // the upstream slot plus this stage's rows.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          a_reg[gi]     <= '0;
          b_reg[gi]     <= '0;
          sum_reg[gi]   <= '0;
`ifdef ARRAY_MULT_SIGNED_EN
          sgn_reg[gi]   <= 1'b0;
`endif
        end else if (!stall) begin
          valid_reg[gi] <= valid_src;
          a_reg[gi]     <= a_src;
          b_reg[gi]     <= b_src;
          sum_reg[gi]   <= sum_next;
`ifdef ARRAY_MULT_SIGNED_EN
          sgn_reg[gi]   <= sgn_src;
`endif
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_array_multiplier_pipe.sv
// tb_array_multiplier_pipe
//   Directed bench for array_multiplier_pipe with WIDTH=8 and STAGES=4.
//   A negedge monitor checks every delivered product against a queue of
//   expected values and accept-time stamps. The signed cases are compiled in
//   when ARRAY_MULT_SIGNED_EN is defined.
module tb_array_multiplier_pipe;
  localparam int W = 8;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
`ifdef ARRAY_MULT_SIGNED_EN
  logic           in_signed;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;

  array_multiplier_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef ARRAY_MULT_SIGNED_EN
    .in_signed  (in_signed),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] exp;
    int             acc_cyc;
    int             stall_snap;
  } item_t;

  item_t          exp_q[$];
  logic [2*W-1:0] cur_exp;
  int             tests_run    = 0;
  int             tests_failed = 0;
  int             cyc          = 0;
  int             stall_total  = 0;
  int             n_out        = 0;
  logic           hold_pending = 1'b0;
  logic [2*W-1:0] held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes, ordering, latency, and output stability during stalls.
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      cyc++;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (hold_pending) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, held);
        hold_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          it = exp_q.pop_front();
          n_out++;
          chk("result", out_result, it.exp);
          chk("latency", cyc - it.acc_cyc, S + stall_total - it.stall_snap);
          $display("[TB] out #%0d result=0x%04h exp=0x%04h", n_out, out_result, it.exp);
        end
      end
      if (out_valid && !out_ready) begin
        stall_total++;
        hold_pending = 1'b1;
        held = out_result;
      end
      if (in_valid && in_ready) exp_q.push_back('{cur_exp, cyc, stall_total});
    end
  end

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int highs;
    int base;
    int st0;
    int cycle;
    int idx;
    logic took;
    logic [W-1:0] va;
    logic [W-1:0] vb;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; cur_exp = '0;
`ifdef ARRAY_MULT_SIGNED_EN
    in_signed = 1'b0;
`endif
    // Reset and idle behaviour.
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_result", out_result, 0);
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_out_valid", out_valid, 0);
    end

    // A single product: out_valid should rise 3 edges after the accept edge
    // and stay high for exactly one cycle.
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; cur_exp = 16'hFE01;
    step();
    in_valid = 1'b0;
    first = -1; highs = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (out_valid) begin
        if (first < 0) first = k;
        highs++;
        chk("single_result", out_result, 16'hFE01);
      end
    end
    chk("single_first_step", first, S - 1);
    chk("single_valid_cycles", highs, 1);

    // Streaming 256 back-to-back pairs, with corner cases at the start.
    base = n_out;
    for (int i = 0; i < 256; i++) begin
      case (i)
        0: begin va = 8'd0;   vb = 8'd173; end
        1: begin va = 8'd91;  vb = 8'd1;   end
        2: begin va = 8'd255; vb = 8'd255; end
        3: begin va = 8'd1;   vb = 8'd0;   end
        4: begin va = 8'd128; vb = 8'd2;   end
        default: begin va = W'($urandom_range(0, 255)); vb = W'($urandom_range(0, 255)); end
      endcase
      in_valid = 1'b1; in_a = va; in_b = vb;
      cur_exp = 16'(va) * 16'(vb);
      step();
    end
    drain();
    chk("stream_count", n_out - base, 256);

    // Backpressure: 10 pairs, with out_ready low for 3 cycles mid-stream.
    base = n_out; st0 = stall_total; cycle = 0; idx = 0;
    while (idx < 10 && cycle < 100) begin
      out_ready = !(cycle >= 6 && cycle <= 8);
      va = W'(idx * 17 + 3); vb = W'(200 - idx * 9);
      in_valid = 1'b1; in_a = va; in_b = vb;
      cur_exp = 16'(va) * 16'(vb);
      #1;
      took = in_ready;
      step();
      if (took) idx++;
      cycle++;
    end
    drain();
    chk("bp_count", n_out - base, 10);
    chk("bp_stall_cycles", stall_total - st0, 3);

    // Asynchronous reset with three products in flight, one already at the output.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = W'(i + 5); in_b = W'(i + 9);
      cur_exp = 16'(i + 5) * 16'(i + 9);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("pre_rst_out_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_result", out_result, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) step();
    rst_n = 1'b1; out_ready = 1'b1;
    highs = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) highs++;
    end
    chk("post_flush_outputs", highs, 0);

`ifdef ARRAY_MULT_SIGNED_EN
    // Signed and unsigned pairs mixed back to back.
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin in_a = 8'h80; in_b = 8'h80; in_signed = 1'b1; cur_exp = 16'h4000; end
        1: begin in_a = 8'hFF; in_b = 8'h7F; in_signed = 1'b1; cur_exp = 16'hFF81; end
        2: begin in_a = 8'hFF; in_b = 8'h7F; in_signed = 1'b0; cur_exp = 16'h7E81; end
        default: begin in_a = 8'hFF; in_b = 8'h7F; in_signed = 1'b1; cur_exp = 16'hFF81; end
      endcase
      in_valid = 1'b1;
      step();
    end
    in_signed = 1'b0;
    drain();
    chk("signed_count", n_out - base, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
